// File: rtl/friscv_axi_or_ctrl_pkg.sv
// Shared types for the friscv AXI outstanding-request controller:
// fence FSM states and fence_type bit positions.
package friscv_axi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    ACK
  } or_state_t;

  localparam int unsigned FENCE_RD = 0;
  localparam int unsigned FENCE_WR = 1;

endpackage

// File: rtl/friscv_axi_or_ctrl_if.sv
// Address-channel handshakes between the friscv master and the interconnect,
// plus the monitored B/R completion handshakes.
interface friscv_axi_or_ctrl_if;

  logic m_awvalid;
  logic m_awready;
  logic s_awvalid;
  logic s_awready;
  logic m_arvalid;
  logic m_arready;
  logic s_arvalid;
  logic s_arready;
  logic bvalid;
  logic bready;
  logic rvalid;
  logic rready;

  modport slave (
    input  m_awvalid, s_awready, m_arvalid, s_arready,
    input  bvalid, bready, rvalid, rready,
    output m_awready, s_awvalid, m_arready, s_arvalid
  );

  modport master (
    output m_awvalid, s_awready, m_arvalid, s_arready,
    output bvalid, bready, rvalid, rready,
    input  m_awready, s_awvalid, m_arready, s_arvalid
  );

endinterface

// File: rtl/friscv_axi_or_ctrl_counter.sv
// One direction of outstanding-request tracking: saturating counter, issue
// gate with AXI valid-stability hold, and completion underflow detection.
module friscv_or_counter #(
  parameter int unsigned MAX_OR = 8,
  parameter              NAME   = "OR_Ctrl",
  localparam int unsigned CNT_W = $clog2(MAX_OR + 1)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             srst,
  input  logic             m_valid,
  output logic             m_ready,
  output logic             s_valid,
  input  logic             s_ready,
  input  logic             cpl_valid,
  input  logic             cpl_ready,
  input  logic             block,
  output logic [CNT_W-1:0] cnt,
  output logic             pending,
  output logic             underflow
);

  if (MAX_OR < 2) begin : g_max_or_check
    $error("%s: MAX_OR must be >= 2", NAME);
  end

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OR);

  logic full;
  logic open;
  logic req_hs;
  logic cpl_hs;

  assign full = (cnt == MAX_CNT);
  // A presented-but-unaccepted valid keeps the gate open so it cannot be withdrawn.
  assign open    = pending | (~full & ~block);
  assign s_valid = m_valid & open;
  assign m_ready = s_ready & open;

  assign req_hs    = s_valid & s_ready;
  assign cpl_hs    = cpl_valid & cpl_ready;
  assign underflow = cpl_hs & (cnt == '0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else if (srst) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      pending <= s_valid & ~s_ready;
      if (req_hs && !cpl_hs && !full) begin
        cnt <= cnt + CNT_W'(1);
      end else if (cpl_hs && !req_hs && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/friscv_axi_or_ctrl.sv
// Outstanding-request controller: per-direction throttling plus a FENCE
// drain sequencer that blocks selected directions until they are empty.
module friscv_axi_or_ctrl
  import friscv_axi_pkg::*;
#(
  parameter              NAME   = "OR_Ctrl",
  parameter int unsigned MAX_OR = 8,
  localparam int unsigned CNT_W = $clog2(MAX_OR + 1)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 srst,
  friscv_axi_or_ctrl_if.slave  bus,
  input  logic                 fence_req,
  input  logic [1:0]           fence_type,
  output logic                 fence_ack,
  output logic [CNT_W-1:0]     wr_or_cnt,
  output logic [CNT_W-1:0]     rd_or_cnt,
  output logic                 or_error
);

  or_state_t  state;
  or_state_t  state_nxt;
  logic [1:0] ftype;
  logic       block_wr;
  logic       block_rd;
  logic       wr_pending;
  logic       rd_pending;
  logic       wr_underflow;
  logic       rd_underflow;
  logic       drain_done;

  assign block_wr = (state == DRAIN) & ftype[FENCE_WR];
  assign block_rd = (state == DRAIN) & ftype[FENCE_RD];

  friscv_or_counter #(
    .MAX_OR (MAX_OR),
    .NAME   (NAME)
  ) u_wr_cnt (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .srst      (srst),
    .m_valid   (bus.m_awvalid),
    .m_ready   (bus.m_awready),
    .s_valid   (bus.s_awvalid),
    .s_ready   (bus.s_awready),
    .cpl_valid (bus.bvalid),
    .cpl_ready (bus.bready),
    .block     (block_wr),
    .cnt       (wr_or_cnt),
    .pending   (wr_pending),
    .underflow (wr_underflow)
  );

  friscv_or_counter #(
    .MAX_OR (MAX_OR),
    .NAME   (NAME)
  ) u_rd_cnt (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .srst      (srst),
    .m_valid   (bus.m_arvalid),
    .m_ready   (bus.m_arready),
    .s_valid   (bus.s_arvalid),
    .s_ready   (bus.s_arready),
    .cpl_valid (bus.rvalid),
    .cpl_ready (bus.rready),
    .block     (block_rd),
    .cnt       (rd_or_cnt),
    .pending   (rd_pending),
    .underflow (rd_underflow)
  );

  // An unselected direction never holds up the drain.
  assign drain_done = (~ftype[FENCE_WR] | ((wr_or_cnt == '0) & ~wr_pending)) &
                      (~ftype[FENCE_RD] | ((rd_or_cnt == '0) & ~rd_pending));

  always_comb begin
    state_nxt = state;
    fence_ack = 1'b0;
    case (state)
      IDLE:    if (fence_req) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = ACK;
      ACK: begin
        fence_ack = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      ftype    <= '0;
      or_error <= 1'b0;
    end else if (srst) begin
      state    <= IDLE;
      ftype    <= '0;
      or_error <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && fence_req) ftype <= fence_type;
      if (wr_underflow || rd_underflow) or_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_friscv_axi_or_ctrl.sv
// Scoreboard bench for friscv_axi_or_ctrl: directed scenarios then random
// traffic, each cycle checked against a transaction-level reference model.
module tb_friscv_axi_or_ctrl;

  localparam int unsigned MAX = 4;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       srst = 1'b0;
  logic       fence_req = 1'b0;
  logic [1:0] fence_type = 2'b00;
  logic       fence_ack;
  logic       or_error;
  logic [2:0] wr_or_cnt;
  logic [2:0] rd_or_cnt;

  friscv_axi_or_ctrl_if bus ();

  friscv_axi_or_ctrl #(
    .NAME   ("OR_Ctrl"),
    .MAX_OR (MAX)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .srst       (srst),
    .bus        (bus),
    .fence_req  (fence_req),
    .fence_type (fence_type),
    .fence_ack  (fence_ack),
    .wr_or_cnt  (wr_or_cnt),
    .rd_or_cnt  (rd_or_cnt),
    .or_error   (or_error)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic awv, awr, arv, arr, ack, err;
    int   wc, rc;
    int   cyc;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle_no = 0;

  // Reference model: outstanding counts, valids still owed, fence progress.
  int   wcnt, rcnt;
  bit   hold_w, hold_r, err;
  bit   draining, ack_now;
  bit [1:0] sel;
  bit   aw_owed, ar_owed, last_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cycle_no, act, exp);
    end
  endtask

  task automatic model_reset();
    wcnt = 0; rcnt = 0; hold_w = 0; hold_r = 0; err = 0;
    draining = 0; ack_now = 0; sel = 2'b00;
  endtask

  task automatic model_cycle();
    exp_t e;
    bit w_open, r_open, aw_hs, ar_hs, b_hs, r_hs, done;
    if (!aresetn) model_reset();
    w_open = hold_w || (wcnt < MAX && !(draining && sel[1]));
    r_open = hold_r || (rcnt < MAX && !(draining && sel[0]));
    e.awv = bus.m_awvalid && w_open;
    e.awr = bus.s_awready && w_open;
    e.arv = bus.m_arvalid && r_open;
    e.arr = bus.s_arready && r_open;
    e.ack = ack_now; e.err = err; e.wc = wcnt; e.rc = rcnt; e.cyc = cycle_no;
    expq.push_back(e);
    aw_owed  = bus.m_awvalid && !e.awr;
    ar_owed  = bus.m_arvalid && !e.arr;
    last_ack = e.ack;
    if (!aresetn) return;
    if (srst) begin model_reset(); return; end
    aw_hs = e.awv && bus.s_awready;
    ar_hs = e.arv && bus.s_arready;
    b_hs  = bus.bvalid && bus.bready;
    r_hs  = bus.rvalid && bus.rready;
    done  = (!sel[1] || (wcnt == 0 && !hold_w)) && (!sel[0] || (rcnt == 0 && !hold_r));
    if (ack_now) ack_now = 0;
    else if (draining) begin
      if (done) begin draining = 0; ack_now = 1; end
    end else if (fence_req) begin
      draining = 1; sel = fence_type;
    end
    if (b_hs && wcnt == 0) err = 1;
    if (r_hs && rcnt == 0) err = 1;
    if (aw_hs && !b_hs && wcnt < MAX) wcnt++;
    else if (b_hs && !aw_hs && wcnt > 0) wcnt--;
    if (ar_hs && !r_hs && rcnt < MAX) rcnt++;
    else if (r_hs && !ar_hs && rcnt > 0) rcnt--;
    hold_w = e.awv && !bus.s_awready;
    hold_r = e.arv && !bus.s_arready;
  endtask

  task automatic cyc();
    model_cycle();
    @(posedge aclk);
    #1;
    cycle_no++;
  endtask

  always @(negedge aclk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("s_awvalid", bus.s_awvalid, e.awv);
      chk("m_awready", bus.m_awready, e.awr);
      chk("s_arvalid", bus.s_arvalid, e.arv);
      chk("m_arready", bus.m_arready, e.arr);
      chk("fence_ack", fence_ack, e.ack);
      chk("or_error", or_error, e.err);
      chk("wr_or_cnt", wr_or_cnt, e.wc);
      chk("rd_or_cnt", rd_or_cnt, e.rc);
    end
  end

  initial begin
    bus.m_awvalid = 0; bus.s_awready = 0; bus.m_arvalid = 0; bus.s_arready = 0;
    bus.bvalid = 0; bus.bready = 0; bus.rvalid = 0; bus.rready = 0;
    model_reset();
    @(posedge aclk); #1;

    // Reset: gates follow inputs with open=1.
    bus.m_awvalid = 1; bus.s_awready = 1;
    repeat (2) cyc();
    chk("rst_wr_cnt", wr_or_cnt, 0);
    chk("rst_err", or_error, 0);
    chk("rst_ack", fence_ack, 0);
    chk("rst_gate", bus.s_awvalid, 1);
    aresetn = 1;

    // Fill writes to MAX, throttle, resume after one B.
    bus.bready = 1; bus.rready = 1;
    repeat (6) cyc();
    chk("wr_full_cnt", wr_or_cnt, 4);
    chk("wr_full_svalid", bus.s_awvalid, 0);
    chk("wr_full_mready", bus.m_awready, 0);
    bus.bvalid = 1; cyc(); bus.bvalid = 0;
    chk("wr_after_b", wr_or_cnt, 3);
    chk("wr_resume", bus.s_awvalid, 1);
    cyc();
    bus.m_awvalid = 0;

    // Reads: simultaneous AR/R at 2, then R at full.
    bus.m_arvalid = 1; bus.s_arready = 1;
    repeat (2) cyc();
    bus.rvalid = 1; cyc(); bus.rvalid = 0;
    chk("rd_simul", rd_or_cnt, 2);
    repeat (3) cyc();
    chk("rd_full", rd_or_cnt, 4);
    bus.rvalid = 1; cyc();
    chk("rd_full_r", rd_or_cnt, 3);
    chk("rd_full_noerr", or_error, 0);
    bus.m_arvalid = 0;
    repeat (3) cyc();
    bus.rvalid = 0;
    bus.bvalid = 1; cyc(); bus.bvalid = 0;
    chk("wr_pre_fence", wr_or_cnt, 3);

    // Write fence with AR traffic continuing.
    fence_req = 1; fence_type = 2'b10; bus.m_arvalid = 1;
    cyc();
    bus.m_awvalid = 1; bus.rvalid = 1;
    cyc();
    chk("fence_aw_blocked", bus.s_awvalid, 0);
    chk("fence_ar_open", bus.s_arvalid, 1);
    repeat (2) begin bus.bvalid = 1; cyc(); bus.bvalid = 0; cyc(); end
    bus.bvalid = 1; cyc(); bus.bvalid = 0;
    chk("fence_ack_early", fence_ack, 0);
    cyc();
    chk("fence_ack_pulse", fence_ack, 1);
    fence_req = 0;
    cyc();
    chk("fence_ack_once", fence_ack, 0);
    bus.m_awvalid = 0; bus.m_arvalid = 0; bus.bvalid = 1;
    cyc();
    bus.bvalid = 0; bus.rvalid = 0;
    cyc();

    // Valid presented before fence must survive the block.
    bus.m_awvalid = 1; bus.s_awready = 0;
    cyc();
    fence_req = 1; fence_type = 2'b10;
    cyc();
    chk("pend_hold", bus.s_awvalid, 1);
    cyc();
    bus.s_awready = 1;
    cyc();
    bus.m_awvalid = 0;
    chk("pend_cnt", wr_or_cnt, 1);
    repeat (3) cyc();
    chk("pend_wait_b", fence_ack, 0);
    bus.bvalid = 1; cyc(); bus.bvalid = 0;
    cyc();
    chk("pend_ack", fence_ack, 1);
    fence_req = 0;
    cyc();

    // Underflow is sticky until srst.
    bus.bvalid = 1; cyc(); bus.bvalid = 0;
    chk("uf_err", or_error, 1);
    chk("uf_cnt", wr_or_cnt, 0);
    repeat (3) cyc();
    chk("uf_sticky", or_error, 1);
    srst = 1; cyc(); srst = 0;
    chk("uf_srst", or_error, 0);

    // Async reset mid-drain.
    bus.m_arvalid = 1;
    repeat (4) cyc();
    bus.m_arvalid = 0;
    chk("arst_pre_rd", rd_or_cnt, 4);
    fence_req = 1; fence_type = 2'b01;
    repeat (3) cyc();
    aresetn = 0;
    #1;
    chk("arst_rd", rd_or_cnt, 0);
    cyc();
    aresetn = 1; fence_req = 0;
    repeat (5) cyc();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.m_awvalid = aw_owed ? 1'b1 : ($urandom_range(0, 1) == 1);
      bus.m_arvalid = ar_owed ? 1'b1 : ($urandom_range(0, 1) == 1);
      bus.s_awready = ($urandom_range(0, 9) < 6);
      bus.s_arready = ($urandom_range(0, 9) < 6);
      bus.bvalid = (wcnt > 0) && ($urandom_range(0, 9) < 4);
      bus.rvalid = (rcnt > 0) && ($urandom_range(0, 9) < 4);
      bus.bready = ($urandom_range(0, 9) < 7);
      bus.rready = ($urandom_range(0, 9) < 7);
      if (last_ack) fence_req = 0;
      else if (!fence_req && $urandom_range(0, 19) == 0) begin
        fence_req = 1;
        fence_type = 2'($urandom_range(0, 3));
      end
      srst = ($urandom_range(0, 299) == 0);
      cyc();
    end
    srst = 0; fence_req = 0;
    bus.m_awvalid = 0; bus.m_arvalid = 0; bus.bvalid = 0; bus.rvalid = 0;
    cyc();
    @(negedge aclk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
